// File: rtl/matmul_pkg.sv
// ============================================================================
//  Module      : matmul_pkg
//  Description : Shared FSM encodings, index lookups and saturation helper
//                for the 2x2 matrix-product sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_LOAD_A  = 3'd0;
    localparam state_t c_LOAD_B  = 3'd1;
    localparam state_t c_COMPUTE = 3'd2;
    localparam state_t c_OUT_HI  = 3'd3;
    localparam state_t c_OUT_LO  = 3'd4;

    localparam int unsigned c_ELEM_MAX = 2;

    // Result element order is c11, c12, c21, c22; bit idx gives its row / column.
    localparam logic [3:0] c_IDX_ROW = 4'b1100;
    localparam logic [3:0] c_IDX_COL = 4'b1010;

    function automatic int unsigned sat(input int unsigned x, input int unsigned lim);
        return (x > lim) ? lim : x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_mac.sv
// ============================================================================
//  Module      : matmul_mac
//  Description : Shared multiply-accumulate unit with saturated result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_mac
    import matmul_pkg::*;
#(
    parameter int ELEM_W = 2,
    parameter int RES_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_load,
    input  logic [ELEM_W-1:0] i_a,
    input  logic [ELEM_W-1:0] i_b,
    output logic [RES_W-1:0]  o_result
);

    localparam int          c_ACC_W   = 2 * ELEM_W + 1;
    localparam int unsigned c_RES_MAX = (1 << RES_W) - 1;

    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] w_prod;
    logic [c_ACC_W-1:0] w_sum;

    assign w_prod = c_ACC_W'(i_a) * c_ACC_W'(i_b);
    assign w_sum  = i_load ? w_prod : (r_acc + w_prod);

    // Result reflects the value the accumulator takes at this edge.
    assign o_result = RES_W'(sat(32'(w_sum), c_RES_MAX));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_enable) begin
            r_acc <= w_sum;
        end
    end

endmodule

`default_nettype wire

// File: rtl/matmul_sequencer.sv
// ============================================================================
//  Module      : matmul_sequencer
//  Description : Time-multiplexes one MAC through a 2x2 unsigned matrix
//                product. Optional macro: MATMUL_RANGE_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int ELEM_W = 2,
    parameter int RES_W  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*ELEM_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*RES_W-1:0]  out_data,
    output logic                busy,
    output logic                error
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [4*ELEM_W-1:0]       r_a;
    logic [4*ELEM_W-1:0]       r_b;
    logic [3:0][RES_W-1:0]     r_c;
    logic [2:0]                r_k;
    logic                      r_out_valid;
    logic [2*RES_W-1:0]        r_out_data;

    logic                      w_accept;
    logic                      w_word_ok;
    logic [1:0]                w_idx;
    logic                      w_t;
    logic [1:0]                w_a_sel;
    logic [1:0]                w_b_sel;
    logic [ELEM_W-1:0]         w_mac_a;
    logic [ELEM_W-1:0]         w_mac_b;
    logic [RES_W-1:0]          w_mac_result;

    assign in_ready  = (r_state == c_LOAD_A) || (r_state == c_LOAD_B);
    assign busy      = (r_state == c_COMPUTE) || (r_state == c_OUT_HI) || (r_state == c_OUT_LO);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef MATMUL_RANGE_CHECK_EN
    logic [3:0] w_elem_oob;
    logic       r_error;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_range
            assign w_elem_oob[gi] = 32'(in_data[gi*ELEM_W +: ELEM_W]) > c_ELEM_MAX;
        end
    endgenerate

    assign w_word_ok = ~|w_elem_oob;
    assign error     = r_error;

    // Sticky until a clean A word is taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_accept && !w_word_ok) begin
            r_error <= 1'b1;
        end else if (w_accept && (r_state == c_LOAD_A)) begin
            r_error <= 1'b0;
        end
    end
`else
    assign w_word_ok = 1'b1;
    assign error     = 1'b0;
`endif

    // k[2:1] selects the result element, k[0] the term of its dot product.
    assign w_idx   = r_k[2:1];
    assign w_t     = r_k[0];
    assign w_a_sel = {c_IDX_ROW[w_idx], w_t};
    assign w_b_sel = {w_t, c_IDX_COL[w_idx]};
    assign w_mac_a = r_a[w_a_sel*ELEM_W +: ELEM_W];
    assign w_mac_b = r_b[w_b_sel*ELEM_W +: ELEM_W];

    matmul_mac #(
        .ELEM_W (ELEM_W),
        .RES_W  (RES_W)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .i_enable (r_state == c_COMPUTE),
        .i_load   (~w_t),
        .i_a      (w_mac_a),
        .i_b      (w_mac_b),
        .o_result (w_mac_result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_LOAD_A:  if (w_accept && w_word_ok) w_state_next = c_LOAD_B;
            c_LOAD_B:  if (w_accept && w_word_ok) w_state_next = c_COMPUTE;
            c_COMPUTE: if (r_k == 3'd7) w_state_next = c_OUT_HI;
            c_OUT_HI:  if (r_out_valid && out_ready) w_state_next = c_OUT_LO;
            c_OUT_LO:  if (r_out_valid && out_ready) w_state_next = c_LOAD_A;
            default:   w_state_next = c_LOAD_A;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_k         <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                c_LOAD_A: begin
                    if (w_accept && w_word_ok) r_a <= in_data;
                end
                c_LOAD_B: begin
                    if (w_accept && w_word_ok) begin
                        r_b <= in_data;
                        r_k <= 3'd0;
                    end
                end
                c_COMPUTE: begin
                    r_k <= r_k + 3'd1;
                    if (w_t) r_c[w_idx] <= w_mac_result;
                end
                c_OUT_HI: begin
                    // First OUT_HI cycle registers word0; later cycles wait for the handshake.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= {r_c[0], r_c[1]};
                    end else if (out_ready) begin
                        r_out_data  <= {r_c[2], r_c[3]};
                    end
                end
                c_OUT_LO: begin
                    if (r_out_valid && out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
// ============================================================================
//  Module      : tb_matmul_sequencer
//  Description : Directed and random checks of matmul_sequencer against a
//                plain matrix-arithmetic model. Honours MATMUL_RANGE_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       error;

    int total = 0;
    int bad   = 0;

    matmul_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .error     (error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Matrix product from element arithmetic; returns {word0, word1}.
    function automatic logic [15:0] ref_mm(input logic [7:0] a, input logic [7:0] b);
        int ea [2][2];
        int eb [2][2];
        int c  [2][2];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ea[i][j] = int'(a[(i*2+j)*2 +: 2]);
                eb[i][j] = int'(b[(i*2+j)*2 +: 2]);
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                c[i][j] = ea[i][0]*eb[0][j] + ea[i][1]*eb[1][j];
                if (c[i][j] > 15) c[i][j] = 15;
            end
        return {4'(c[0][0]), 4'(c[0][1]), 4'(c[1][0]), 4'(c[1][1])};
    endfunction

    function automatic logic [7:0] rand_word(input int emax);
        logic [7:0] w;
        for (int i = 0; i < 4; i++) w[i*2 +: 2] = 2'($urandom_range(0, emax));
        return w;
    endfunction

    task automatic send(input logic [7:0] d, input string tag);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        check({tag, "_accept"}, 32'(done), 32'd1);
    endtask

    task automatic recv(output logic [7:0] w, input string tag);
        bit done;
        done      = 0;
        w         = 8'hxx;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (out_valid) begin
                w = out_data;
                @(posedge clock);
                #1;
                done = 1;
            end
        end
        out_ready = 1'b0;
        check({tag, "_handshake"}, 32'(done), 32'd1);
    endtask

    task automatic run_pair(input logic [7:0] a, input logic [7:0] b, input string tag,
                            input bit check_latency);
        logic [15:0] exp;
        logic [7:0]  w;
        int          lat;
        exp = ref_mm(a, b);
        send(a, {tag, "_A"});
        send(b, {tag, "_B"});
        if (check_latency) begin
            lat = 0;
            for (int i = 1; i <= 30 && lat == 0; i++) begin
                @(posedge clock);
                #1;
                if (i == 1) check({tag, "_busy_compute"}, 32'(busy), 32'd1);
                if (out_valid) lat = i;
            end
            check({tag, "_latency"}, 32'(lat), 32'd9);
        end
        recv(w, {tag, "_w0"});
        check({tag, "_word0"}, 32'(w), 32'(exp[15:8]));
        recv(w, {tag, "_w1"});
        check({tag, "_word1"}, 32'(w), 32'(exp[7:0]));
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] ra;
        logic [7:0] rb;
        int         emax;
        bit         seen;

`ifdef MATMUL_RANGE_CHECK_EN
        emax = 2;
`else
        emax = 3;
`endif

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_error",     32'(error),     32'd0);

        // Worked example with latency measurement.
        run_pair(8'h49, 8'h16, "t1", 1'b1);
        check("t1_ref_w0", 32'(ref_mm(8'h49, 8'h16)), 32'h4110);

        // All twos.
        run_pair(8'hAA, 8'hAA, "t2", 1'b0);
        check("t2_error", 32'(error), 32'd0);

        // Backpressure on word0.
        send(8'h49, "t3_A");
        send(8'h16, "t3_B");
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clock);
            #1;
            seen = out_valid;
        end
        check("t3_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_data",  32'(out_data),  32'h41);
        end
        recv(w, "t3_w0");
        check("t3_word0", 32'(w), 32'h41);
        recv(w, "t3_w1");
        check("t3_word1", 32'(w), 32'h10);
        @(posedge clock);
        #1;
        check("t3_valid_drop", 32'(out_valid), 32'd0);
        check("t3_in_ready",   32'(in_ready),  32'd1);

        // Out-of-range elements.
`ifdef MATMUL_RANGE_CHECK_EN
        send(8'hFF, "t4_bad");
        check("t4_error_set", 32'(error),    32'd1);
        check("t4_busy",      32'(busy),     32'd0);
        check("t4_in_ready",  32'(in_ready), 32'd1);
        repeat (12) @(posedge clock);
        #1;
        check("t4_no_output", 32'(out_valid), 32'd0);
        check("t4_still_err", 32'(error),     32'd1);
        run_pair(8'h49, 8'h16, "t4_after", 1'b0);
        check("t4_error_clr", 32'(error), 32'd0);
`else
        run_pair(8'hFF, 8'hFF, "t4", 1'b0);
        check("t4_error", 32'(error), 32'd0);
`endif

        // Reset in the middle of COMPUTE.
        send(8'hAA, "t5_A");
        send(8'hFF, "t5_B");
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("t5_in_ready",  32'(in_ready),  32'd1);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_busy",      32'(busy),      32'd0);
        run_pair(8'h16, 8'h49, "t5_after", 1'b1);

        // in_valid held with junk while busy.
        send(8'h5A, "t6_A");
        send(8'h29, "t6_B");
        in_valid = 1'b1;
        in_data  = 8'h99;
        recv(w, "t6_w0");
        check("t6_word0", 32'(w), 32'(ref_mm(8'h5A, 8'h29) >> 8));
        recv(w, "t6_w1");
        in_valid = 1'b0;
        check("t6_word1", 32'(w), 32'(ref_mm(8'h5A, 8'h29) & 16'h00FF));
        check("t6_in_ready", 32'(in_ready), 32'd1);

        // Random operands.
        for (int n = 0; n < 10; n++) begin
            ra = rand_word(emax);
            rb = rand_word(emax);
            run_pair(ra, rb, "rand", 1'b0);
        end
        check("end_error", 32'(error), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
